// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the core's single-port memory arbiter.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds default bus widths, the arbiter state encoding and the counter ceiling.
package riscv_mem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

    typedef enum logic {
        NORMAL   = 1'b0,
        FORCE_IF = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and data access; data wins, fetch forced after MAX_WAIT denials.
// Latency: grant combinational in the request cycle, read data/rvalid registered one cycle later.
// Backpressure: losing requester holds req/addr/data until its gnt; no queuing inside.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              Reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,

    output logic [15:0]       conflict_cnt
);

    localparam logic [3:0] MAX_WAIT_V = 4'(MAX_WAIT);

    arb_state_t state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       force_if;

    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        state_d   = state_q;

        // In FORCE_IF a present fetch beats data; an absent one lets data through.
        force_if = (state_q == FORCE_IF) && if_req;

        if (!Reset) begin
            d_gnt  = d_req && !force_if;
            if_gnt = if_req && !d_gnt;
        end

        if (d_gnt) begin
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
            ram_we    = d_we;
        end else if (if_gnt) begin
            ram_addr  = if_addr;
        end

        wait_d = (if_req && !if_gnt) ? wait_q + 4'd1 : 4'd0;

        case (state_q)
            NORMAL:   if (wait_d == MAX_WAIT_V) state_d = FORCE_IF;
            FORCE_IF: if (if_gnt || !if_req)    state_d = NORMAL;
            default:  state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= NORMAL;
            wait_q       <= '0;
            if_rvalid    <= 1'b0;
            d_rvalid     <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            conflict_cnt <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            if_rvalid <= if_gnt;
            d_rvalid  <= d_gnt;
            if (if_gnt) begin
                if_rdata <= ram_rdata;
            end
            // Stores still pulse d_rvalid but leave the last load data in place.
            if (d_gnt && !d_we) begin
                d_rdata <= ram_rdata;
            end
            if (if_req && d_req && conflict_cnt != CONFLICT_MAX) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a RAM model and a spec-level reference arbiter.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [15:0]   conflict_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .Reset(Reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
    );

    // Physical RAM: combinational read, write on rising edge.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            denied = 0;
    int            ref_conflict = 0;
    logic [DW-1:0] last_load = '0;
    logic          m_gi, m_gd;

    typedef struct {
        int            cyc;
        logic [DW-1:0] dat;
    } resp_t;
    resp_t if_q[$];
    resp_t d_q[$];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs after the edge, check against the model mid-cycle.
    task automatic step(input logic rst, input logic ireq, input logic [AW-1:0] ia,
                        input logic dreq, input logic dwe, input logic [AW-1:0] da,
                        input logic [DW-1:0] dw);
        logic exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        @(posedge clk);
        #1;
        Reset = rst; if_req = ireq; if_addr = ia;
        d_req = dreq; d_we = dwe; d_addr = da; d_wdata = dw;
        @(negedge clk);

        check("conflict_cnt", 64'(conflict_cnt), 64'(ref_conflict));

        if (rst) begin
            m_gd = 1'b0;
            m_gi = 1'b0;
        end else begin
            // Data wins unless fetch has already been passed over MW times in a row.
            m_gd = dreq && !(ireq && denied == MW);
            m_gi = ireq && !m_gd;
        end
        exp_we    = m_gd && dwe;
        exp_addr  = m_gd ? da : (m_gi ? ia : '0);
        exp_wdata = m_gd ? dw : '0;
        check("if_gnt", 64'(if_gnt), 64'(m_gi));
        check("d_gnt", 64'(d_gnt), 64'(m_gd));
        check("ram_we", 64'(ram_we), 64'(exp_we));
        check("ram_addr", 64'(ram_addr), 64'(exp_addr));
        check("ram_wdata", 64'(ram_wdata), 64'(exp_wdata));

        if (m_gd) begin
            if (dwe) begin
                d_q.push_back('{cyc + 1, last_load});
                ref_mem[da] = dw;
            end else begin
                last_load = ref_mem[da];
                d_q.push_back('{cyc + 1, last_load});
            end
        end
        if (m_gi) if_q.push_back('{cyc + 1, ref_mem[ia]});

        if (rst) begin
            denied = 0;
            ref_conflict = 0;
            last_load = '0;
        end else begin
            denied = (ireq && !m_gi) ? denied + 1 : 0;
            if (ireq && dreq && ref_conflict < 65535) ref_conflict++;
        end
    endtask

    // Monitor: every cycle, rvalid must match the scoreboard head and carry its data.
    always @(negedge clk) begin
        logic exp_v;
        resp_t e;
        exp_v = (if_q.size() > 0) && (if_q[0].cyc == cyc);
        check("if_rvalid", 64'(if_rvalid), 64'(exp_v));
        if (exp_v) begin
            e = if_q.pop_front();
            check("if_rdata", 64'(if_rdata), 64'(e.dat));
        end
        exp_v = (d_q.size() > 0) && (d_q[0].cyc == cyc);
        check("d_rvalid", 64'(d_rvalid), 64'(exp_v));
        if (exp_v) begin
            e = d_q.pop_front();
            check("d_rdata", 64'(d_rdata), 64'(e.dat));
        end
    end

    initial begin
        logic          ip, dp, dwe_r;
        logic [AW-1:0] ia_r, da_r;
        logic [DW-1:0] dw_r;

        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        ram[4] = 32'h00500093;
        ref_mem[4] = 32'h00500093;

        // Reset with both requesters active
        step(1, 1, 10'h004, 1, 0, 10'h010, 32'h0);
        step(1, 1, 10'h004, 1, 0, 10'h010, 32'h0);
        step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0);
        check("reset_if_rdata", 64'(if_rdata), 64'h0);
        check("reset_d_rdata", 64'(d_rdata), 64'h0);

        // Fetch only
        step(0, 1, 10'h004, 0, 0, 10'h000, 32'h0);
        step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0);
        check("fetch_rdata", 64'(if_rdata), 64'h00500093);

        // Store then load of the same word
        step(0, 0, 10'h000, 1, 1, 10'h020, 32'hDEADBEEF);
        step(0, 0, 10'h000, 1, 0, 10'h020, 32'h0);
        step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0);
        check("store_load_rdata", 64'(d_rdata), 64'hDEADBEEF);

        // Starvation: fetch forced every MW+1 cycles
        for (int k = 0; k < 3 * (MW + 1); k++) begin
            step(0, 1, 10'h008, 1, 0, 10'h020, 32'h0);
            check("starve_if_gnt", 64'(if_gnt), 64'((k % (MW + 1)) == MW));
        end
        step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0);

        // Reach FORCE_IF then drop fetch: data goes through, arbiter back to normal
        for (int k = 0; k < MW; k++) step(0, 1, 10'h008, 1, 0, 10'h021, 32'h0);
        step(0, 0, 10'h000, 1, 0, 10'h021, 32'h0);
        check("force_exit_d_gnt", 64'(d_gnt), 64'h1);
        step(0, 1, 10'h008, 1, 0, 10'h021, 32'h0);
        check("force_exit_normal", 64'(d_gnt), 64'h1);
        step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0);

        // Randomized traffic over a small address window to provoke hazards
        ip = 0; dp = 0; dwe_r = 0; ia_r = '0; da_r = '0; dw_r = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!ip) begin
                ip = ($urandom_range(0, 9) < 6);
                ia_r = AW'($urandom_range(0, 31));
            end else if ($urandom_range(0, 19) == 0) begin
                ip = 0;
            end
            if (!dp) begin
                dp = ($urandom_range(0, 9) < 5);
                dwe_r = 1'($urandom_range(0, 1));
                da_r = AW'($urandom_range(0, 31));
                dw_r = $urandom;
            end
            step(0, ip, ia_r, dp, dwe_r, da_r, dw_r);
            if (m_gi) ip = 0;
            if (m_gd) dp = 0;
        end
        step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0);

        // Counter saturation from a preloaded value
        #1;
        force dut.conflict_cnt = 16'hFFF0;
        release dut.conflict_cnt;
        ref_conflict = 16'hFFF0;
        for (int k = 0; k < 24; k++) step(0, 1, 10'h008, 1, 0, 10'h020, 32'h0);
        step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0);
        check("conflict_saturated", 64'(conflict_cnt), 64'hFFFF);

        // Reset arriving while a data load is requested
        step(0, 0, 10'h000, 1, 0, 10'h020, 32'h0);
        step(1, 0, 10'h000, 1, 0, 10'h021, 32'h0);
        step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0);
        check("reset_mid_d_rvalid", 64'(d_rvalid), 64'h0);
        check("reset_mid_d_rdata", 64'(d_rdata), 64'h0);
        check("reset_mid_conflict", 64'(conflict_cnt), 64'h0);

        step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0);
        step(0, 0, 10'h000, 0, 0, 10'h000, 32'h0);
        check("if_queue_drained", 64'(if_q.size()), 64'h0);
        check("d_queue_drained", 64'(d_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
